rv_div_iter: RTL and testbench
==============================

Name: rv_div_iter

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU operations.
- Sits directly downstream of the mul/div issue split. Consumes the div_valid request and operands, and returns one result per accepted request over a valid/ready handshake.
- Multiplication is handled elsewhere; this block only divides.
- One operation is in flight at a time.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rstb  input  1  reset, asynchronous, active-low
flush  input  1  synchronous abort of any in-flight or completed-unconsumed operation
in_valid  input  1  request valid (driven from div_valid)
in_ready  output  1  block can accept a request
op  input  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU
a  input  XLEN  dividend
b  input  XLEN  divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  quotient or remainder per op
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rstb low, asynchronous):
  - state=IDLE, out_valid=0, result=0, busy=0, counter=0; internal quotient/remainder registers cleared.
  - in_ready=1 once rstb is high.
  - Reset asserted mid-operation discards the operation with no output.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance on the edge where in_valid & in_ready & ~flush, called edge T0.
  - At T0, latch op and sign flags. For signed ops (DIV/REM), latch |a| and |b| with the two's-complement magnitude; for unsigned ops, latch a and b raw.
  - Special-case check at T0:
    - b==0 → go directly to DONE at T0.
    - signed op with a==0x8000_0000 and b==0xFFFF_FFFF → go directly to DONE at T0.
    - Otherwise go to CALC with counter=0.
- Special-case results:
  - Divide by zero: quotient = all ones (0xFFFF_FFFF), remainder = a (original operand, unmodified).
  - Signed overflow: quotient = 0x8000_0000, remainder = 0.
  - Fast-path latency: out_valid high after edge T0, i.e. visible in the cycle following acceptance.
- CALC:
  - One quotient bit per cycle, MSB first: shift remainder left one bit inserting the next dividend bit, trial-subtract the divisor, keep if non-negative, set quotient bit.
  - Remainder register is XLEN+1 bits wide.
  - counter increments each cycle. On the edge where counter reaches XLEN-1, go to DONE.
- Sign fix and result register:
  - Applied on the transition into DONE.
  - Quotient is negated if sign(a)≠sign(b) (signed ops only).
  - Remainder is negated if a is negative (REM only); the remainder sign follows the dividend.
  - result is registered and holds the value selected by op.
- Normal latency: out_valid first high after edge T0+XLEN (33 rising edges from acceptance inclusive for XLEN=32).
- DONE:
  - out_valid=1; result and out_valid stay stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE next edge: out_valid=0, in_ready=1.
  - in_ready=0 in DONE. Back-to-back throughput is one op per XLEN+2 cycles worst case.
- flush:
  - Highest priority over in_valid and out_ready in the same cycle.
  - Any state goes to IDLE on the next edge with out_valid=0.
  - A request presented in the same cycle as flush is not accepted.
- in_ready=0 and busy=1 in CALC and DONE.
- Operands a/b/op are sampled only at acceptance; later changes have no effect.
- No X propagation: result holds its last value when out_valid=0.

Test Plan:
- DIVU a=100, b=7 → result 14 (0x0000_000E); REMU same operands → 2. out_valid rises exactly 33 edges after acceptance; in_ready=0 throughout.
- DIV a=0xFFFF_FFF9 (-7), b=2 → 0xFFFF_FFFD (-3). REM same operands → 0xFFFF_FFFF (-1). REM a=7, b=0xFFFF_FFFE (-2) → 1.
- b=0: DIVU a=5 → 0xFFFF_FFFF; REMU a=5 → 5; DIV a=0xFFFF_FFF9 → 0xFFFF_FFFF; REM a=0xFFFF_FFF9 → 0xFFFF_FFF9. All with out_valid in the cycle after acceptance.
- Overflow: DIV a=0x8000_0000, b=0xFFFF_FFFF → 0x8000_0000; REM same operands → 0. Fast-path latency. DIVU with the same operands takes the normal path → 0, 33-edge latency.
- Backpressure and flush:
  - Hold out_ready=0 for 5 cycles in DONE → result and out_valid stable, in_ready=0.
  - Raise out_ready → in_ready=1 on the next cycle, and a second request is accepted.
  - flush at iteration 10 → out_valid never asserts; in_ready=1 on the next cycle.
- Reset mid-CALC: drop rstb asynchronously at iteration 20 → out_valid=0, busy=0 immediately. After release, a new DIVU 0xFFFF_FFFF/0x10 → 0x0FFF_FFFF.

Source files
------------

// File: rtl/rv_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : rv_div_iter
// Description : Iterative radix-2 restoring divider for RV32M DIV, DIVU, REM
//               and REMU. One operation in flight at a time, one quotient
//               bit per cycle, MSB first. Divide-by-zero and signed overflow
//               bypass the iteration and complete in the cycle after
//               acceptance.
//
// Ports       : clk        rising-edge clock
//               rstb       asynchronous active-low reset
//               flush      synchronous abort of any pending/completed op
//               in_valid   request valid
//               in_ready   block can accept a request (IDLE only)
//               op         00 DIV, 01 DIVU, 10 REM, 11 REMU
//               a          dividend
//               b          divisor
//               out_valid  result valid (held until out_ready)
//               out_ready  consumer accepts result
//               result     quotient or remainder selected by op
//               busy       high whenever not IDLE
//
// Revision    : 1.0 - initial release
// ============================================================================
module rv_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    // Iteration counter width; derived from XLEN, not meant to be overridden.
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [XLEN-1:0]  c_int_min  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  c_all_ones = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic               r_neg_q;    // quotient must be negated at the end
    logic               r_neg_r;    // remainder must be negated at the end
    logic [XLEN-1:0]    r_dvsr;     // divisor magnitude
    logic [XLEN-1:0]    r_quo;      // dividend bits shift out, quotient bits shift in
    logic [XLEN:0]      r_rem;      // partial remainder, one guard bit
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_busy;
    logic [XLEN-1:0]    r_result;

    // ------------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ------------------------------------------------------------------------
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_a_mag;
    logic [XLEN-1:0]    w_b_mag;
    logic               w_div_zero;
    logic               w_ovf;

    always_comb begin
        // op[0] clear selects the signed variants (DIV, REM).
        w_signed   = ~op[0];
        w_a_neg    = w_signed & a[XLEN-1];
        w_b_neg    = w_signed & b[XLEN-1];
        w_a_mag    = w_a_neg ? -a : a;
        w_b_mag    = w_b_neg ? -b : b;
        w_div_zero = (b == '0);
        w_ovf      = w_signed & (a == c_int_min) & (b == c_all_ones);
    end

    // ------------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------------
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_diff;
    logic               w_keep;
    logic [XLEN:0]      w_rem_next;
    logic [XLEN-1:0]    w_quo_next;
    logic [XLEN-1:0]    w_q_fix;
    logic [XLEN-1:0]    w_r_fix;

    always_comb begin
        // Bring the next dividend bit (MSB of r_quo) into the remainder.
        w_shift    = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
        w_diff     = w_shift - {1'b0, r_dvsr};
        // A set guard bit means the true shifted value exceeds any XLEN-bit
        // divisor, so the subtraction is always kept in that case.
        w_keep     = r_rem[XLEN] | ~w_diff[XLEN];
        w_rem_next = w_keep ? w_diff : w_shift;
        w_quo_next = {r_quo[XLEN-2:0], w_keep};

        // Sign fix-up applied on the final step; remainder follows dividend.
        w_q_fix    = r_neg_q ? -w_quo_next : w_quo_next;
        w_r_fix    = r_neg_r ? -w_rem_next[XLEN-1:0] : w_rem_next[XLEN-1:0];
    end

    // ------------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dvsr      <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_result    <= '0;
        end else if (flush) begin
            // Abort wins over a new request and over a result handshake.
            // r_result is left untouched so the output never goes undefined.
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op       <= op;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_dvsr     <= w_b_mag;
                        r_quo      <= w_a_mag;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_div_zero) begin
                            // Quotient all ones, remainder is the raw dividend.
                            r_result    <= op[1] ? a : c_all_ones;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_ovf) begin
                            r_result    <= op[1] ? '0 : c_int_min;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state     <= ST_CALC;
                        end
                    end
                end

                ST_CALC: begin
                    r_quo <= w_quo_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        r_result    <= r_op[1] ? w_r_fix : w_q_fix;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_rv_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_div_iter
// Description : Self-checking bench for rv_div_iter. A transaction-level
//               model predicts out_valid/in_ready/busy/result every cycle;
//               directed cases pin the model to hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_div_iter;

    localparam int          XLEN  = 32;
    localparam logic [31:0] C_MIN = 32'h8000_0000;
    localparam logic [31:0] C_ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    rv_div_iter #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference arithmetic (RISC-V M semantics)
    // ------------------------------------------------------------------------
    function automatic logic [31:0] ref_result(input logic [1:0] f_op,
                                               input logic [31:0] fa,
                                               input logic [31:0] fb);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = fa;
        sb = fb;
        if (fb == 32'd0)
            return f_op[1] ? fa : C_ONES;
        if (!f_op[0] && fa == C_MIN && fb == C_ONES)
            return f_op[1] ? 32'd0 : C_MIN;
        case (f_op)
            2'b00:   return $unsigned(sa / sb);
            2'b01:   return fa / fb;
            2'b10:   return $unsigned(sa % sb);
            default: return fa % fb;
        endcase
    endfunction

    // Rising edges from acceptance (inclusive) until out_valid is visible.
    function automatic int ref_latency(input logic [1:0] f_op,
                                       input logic [31:0] fa,
                                       input logic [31:0] fb);
        if (fb == 32'd0) return 1;
        if (!f_op[0] && fa == C_MIN && fb == C_ONES) return 1;
        return XLEN + 1;
    endfunction

    // ------------------------------------------------------------------------
    // Transaction-level model: idle / waiting N edges / holding a result
    // ------------------------------------------------------------------------
    int          m_wait = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_wait   <= 0;
            m_valid  <= 1'b0;
            m_result <= '0;
        end else if (flush) begin
            m_wait  <= 0;
            m_valid <= 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_valid  <= 1'b1;
                m_result <= m_pend;
            end
        end else if (in_valid) begin
            if (ref_latency(op, a, b) == 1) begin
                m_valid  <= 1'b1;
                m_result <= ref_result(op, a, b);
            end else begin
                m_wait <= ref_latency(op, a, b) - 1;
                m_pend <= ref_result(op, a, b);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rstb) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid && m_wait == 0)});
            check("busy", {31'd0, busy}, {31'd0, (m_valid || m_wait != 0)});
            check("result", result, m_result);
        end
    end

    // ------------------------------------------------------------------------
    // Directed single operation with literal expectations
    // ------------------------------------------------------------------------
    task automatic run_op(input string name, input logic [1:0] t_op,
                          input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] exp_lit, input int exp_lat, input int hold);
        int          lat;
        logic        saw_ready;
        logic        unstable;
        logic [31:0] held;
        check({name, " model"}, ref_result(t_op, ta, tb_v), exp_lit);
        op = t_op; a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        // Operands must have been captured; scramble them.
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 1;
        saw_ready = 1'b0;
        while (!out_valid && lat < 100) begin
            saw_ready |= in_ready;
            @(posedge clk); #1;
            lat++;
        end
        check({name, " valid"}, {31'd0, out_valid}, 32'd1);
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, result, exp_lit);
        check({name, " ready low while calc"}, {31'd0, saw_ready}, 32'd0);
        held = result;
        unstable = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) unstable = 1'b1;
        end
        if (hold > 0) check({name, " hold stable"}, {31'd0, unstable}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " ready after handshake"}, {31'd0, in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom % 8)
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return C_ONES;
            3:       return C_MIN;
            4:       return $urandom % 16;
            5:       return -($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin : main
        logic saw_valid;
        repeat (3) @(posedge clk);
        #3 rstb = 1'b1;
        @(posedge clk); #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset result", result, 32'd0);

        // Normal path, with 5 cycles of backpressure, then back-to-back.
        run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'h0000_000E, 33, 5);
        run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 0);
        run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
        // Divide by zero fast path.
        run_op("divu 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 2);
        run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op("div -7/0", 2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("rem -7/0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 0);
        // Signed overflow fast path; unsigned takes the normal path.
        run_op("div ovf", 2'b00, C_MIN, C_ONES, C_MIN, 1, 0);
        run_op("rem ovf", 2'b10, C_MIN, C_ONES, 32'd0, 1, 0);
        run_op("divu min/ones", 2'b01, C_MIN, C_ONES, 32'd0, 33, 0);

        // Flush at iteration 10, with a competing request in the same cycle.
        op = 2'b01; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        check("flush busy", {31'd0, busy}, 32'd0);
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw_valid |= out_valid;
        end
        check("flush no result", {31'd0, saw_valid}, 32'd0);

        // Asynchronous reset at iteration 20.
        op = 2'b00; a = 32'd12345; b = 32'd17; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        #2 rstb = 1'b0;
        #1;
        check("async reset out_valid", {31'd0, out_valid}, 32'd0);
        check("async reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk); #2 rstb = 1'b1;
        @(posedge clk); #1;
        run_op("divu after reset", 2'b01, C_ONES, 32'h10, 32'h0FFF_FFFF, 33, 0);

        // Randomized traffic with random backpressure and occasional flush.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            op        = 2'($urandom);
            a         = pick_val();
            b         = pick_val();
            out_ready = ($urandom % 2) == 0;
            flush     = ($urandom % 64) == 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("drain idle", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
